// File: rtl/switch_encoder_16x4.sv
// Switch-bank priority encoder: synchronizes and debounces 16 slide switches, then
// registers the index of the highest accepted switch plus valid/multi-hot/change flags.
module switch_encoder_16x4 #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_in,
    input  logic        enable,
    output logic [3:0]  code,
    output logic        valid,
    output logic        multi_hot,
    output logic        change,
    output logic [15:0] onehot_echo
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      r_sw_s1;
    logic [15:0]      r_sw_s2;
    logic             r_en_s1;
    logic             r_en_s2;
    logic [15:0]      r_cand;
    logic [15:0]      r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_multi;
    logic             r_change;
    logic [15:0]      r_echo;

    logic [3:0]       w_code;
    logic             w_valid;
    logic             w_multi;
    logic [15:0]      w_echo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_en_s1 <= 1'b0;
            r_en_s2 <= 1'b0;
        end else begin
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
            r_en_s1 <= enable;
            r_en_s2 <= r_en_s1;
        end
    end

    // The whole vector debounces as one unit: any toggling bit restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else if (r_sw_s2 != r_cand) begin
            r_cand <= r_sw_s2;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_stable[i]) w_code = 4'(i);
        end
        w_valid = r_en_s2 & (|r_stable);
        // Clearing the lowest set bit leaves something only when two or more bits are set.
        w_multi = r_en_s2 & (|(r_stable & (r_stable - 16'd1)));
        if (!r_en_s2) w_code = 4'd0;
        w_echo = w_valid ? (16'd1 << w_code) : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code   <= 4'd0;
            r_valid  <= 1'b0;
            r_multi  <= 1'b0;
            r_change <= 1'b0;
            r_echo   <= '0;
        end else begin
            r_code   <= w_code;
            r_valid  <= w_valid;
            r_multi  <= w_multi;
            r_change <= ({w_valid, w_code} != {r_valid, r_code});
            r_echo   <= w_echo;
        end
    end

    assign code        = r_code;
    assign valid       = r_valid;
    assign multi_hot   = r_multi;
    assign change      = r_change;
    assign onehot_echo = r_echo;

endmodule

// File: tb/tb_switch_encoder_16x4.sv
// Directed bench for switch_encoder_16x4: expected output states are queued with the
// edge they must appear on, and a monitor checks them whenever change pulses.
module tb_switch_encoder_16x4;

    localparam int D   = 4;
    localparam int LAT = D + 4;
    localparam int EW  = 54;  // {cycle[31:0], valid, multi_hot, code[3:0], echo[15:0]}

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_in;
    logic        enable;
    logic [3:0]  code;
    logic        valid;
    logic        multi_hot;
    logic        change;
    logic [15:0] onehot_echo;

    logic [EW-1:0] exp_q[$];
    int            cyc;
    int            total;
    int            bad;
    bit            mon_on;

    switch_encoder_16x4 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .enable      (enable),
        .code        (code),
        .valid       (valid),
        .multi_hot   (multi_hot),
        .change      (change),
        .onehot_echo (onehot_echo)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks (called right after a falling edge)
    task automatic expect_at(input int delay, input logic v, input logic m,
                             input logic [3:0] c, input logic [15:0] e);
        logic [31:0] at;
        at = 32'(cyc + delay);
        exp_q.push_back({at, v, m, c, e});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [21:0] act, input logic [21:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [21:0]   cur;
        logic [EW-1:0] ent;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (!rst_n) begin
                    cur = '0;
                    check_out("reset_outputs", {valid, multi_hot, code, onehot_echo, change, 1'b0}, 22'h0);
                end else if (change === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_change at cycle %0d: got %h want no pulse", cyc,
                                 {valid, multi_hot, code, onehot_echo});
                    end else begin
                        ent = exp_q.pop_front();
                        total++;
                        if (ent[53:22] != 32'(cyc)) begin
                            bad++;
                            $display("FAIL change_timing: got cycle %0d want cycle %0d", cyc, ent[53:22]);
                        end
                        cur = ent[21:0];
                        check_out("change_state", {valid, multi_hot, code, onehot_echo}, cur);
                    end
                end else begin
                    check_out("hold_state", {valid, multi_hot, code, onehot_echo}, cur);
                end
            end
        end
    end

    // stimulus
    initial begin
        total  = 0;
        bad    = 0;
        mon_on = 1'b0;
        rst_n  = 1'b1;
        sw_in  = 16'h0000;
        enable = 1'b1;
        #3;
        rst_n  = 1'b0;
        mon_on = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(12);

        // single switch: code 5 after LAT edges
        sw_in = 16'h0020;
        expect_at(LAT, 1'b1, 1'b0, 4'd5, 16'h0020);
        wait_cycles(12);

        // three-cycle bounce must be ignored
        sw_in = 16'h0021;
        wait_cycles(3);
        sw_in = 16'h0020;
        wait_cycles(12);

        sw_in = 16'h8021;
        expect_at(LAT, 1'b1, 1'b1, 4'd15, 16'h8000);
        wait_cycles(12);

        sw_in = 16'h0400;
        expect_at(LAT, 1'b1, 1'b0, 4'd10, 16'h0400);
        wait_cycles(12);

        // enable is only synchronized: 3 edges
        enable = 1'b0;
        expect_at(3, 1'b0, 1'b0, 4'd0, 16'h0000);
        wait_cycles(8);
        enable = 1'b1;
        expect_at(3, 1'b1, 1'b0, 4'd10, 16'h0400);
        wait_cycles(8);

        // valid alone changing still pulses while code stays 0
        sw_in = 16'h0000;
        expect_at(LAT, 1'b0, 1'b0, 4'd0, 16'h0000);
        wait_cycles(12);
        sw_in = 16'h0001;
        expect_at(LAT, 1'b1, 1'b0, 4'd0, 16'h0001);
        wait_cycles(12);

        sw_in = 16'hFFFF;
        expect_at(LAT, 1'b1, 1'b1, 4'd15, 16'h8000);
        wait_cycles(12);

        // reset in the middle of debouncing a new value
        sw_in = 16'h0100;
        wait_cycles(4);
        rst_n = 1'b0;
        #1;
        check_out("async_reset", {valid, multi_hot, code, onehot_echo, change, 1'b0}, 22'h0);
        wait_cycles(2);
        rst_n = 1'b1;
        expect_at(LAT, 1'b1, 1'b0, 4'd8, 16'h0100);
        wait_cycles(12);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
